vt52_key_encoder: RTL
=====================

// Module: vt52_key_encoder
// PURPOSE
//  Terminal-to-host byte encoder; the transmit-side counterpart of the VT52 command handler.
//  Converts key codes into the VT52 byte stream sent to the host: ASCII passes through;
//  cursor and PF keys become ESC sequences.
//  Also answers the host identify request (ESC Z) with ESC / <IDENT_BYTE>.
//  Sits between the keyboard and the UART transmit stream input (valid/ready).
// PARAMETERS
//  CRLF        0      1: key 0x0D emits CR,LF (0x0D,0x0A); 0: emits 0x0D only
//  IDENT_BYTE  8'h4B  third byte of identify response ('K' = VT52, no copier)
//  DROP_BITS   8      width of drop_count
// PORTS
//  clk         in   1          system clock
//  reset       in   1          asynchronous, active-high reset
//  key_code    in   8          key code from keyboard
//  key_valid   in   1          key_code valid
//  key_ready   out  1          key accepted when key_valid & key_ready
//  ident_req   in   1          one-cycle pulse from command handler on ESC Z
//  data        out  8          byte to UART transmitter
//  valid       out  1          data valid
//  ready       in   1          transmitter accepts byte when valid & ready
//  busy        out  1          FSM not IDLE or identify pending
//  drop_count  out  DROP_BITS  count of unmapped key codes; saturates at all-ones
// BEHAVIOUR
//  Reset (async, immediate): valid=0, data=0, busy=0, drop_count=0, ident_pend=0, state=IDLE.
//  Reset asserted mid-sequence: the sequence is abandoned; no resume after release.
//  Key map:
//    0x00-0x7F: one byte, the code itself (0x0D: see CRLF)
//    0x80/81/82/83: ESC A/B/C/D (up/down/right/left)
//    0x84/85/86: ESC P/Q/R (PF1-PF3)
//    0x87-0xFF: consumed; no output; drop_count+1 (saturating)
//  FSM states: IDLE, B0, B1, B2 (B0..B2 = byte index of current sequence, max 3 bytes).
//  key_ready is combinational: (state==IDLE) & ~ident_pend & ~ident_req.
//  ident_req sets ident_pend in any state.
//    - Requests while pending or during an identify send merge: exactly one response is sent.
//  IDLE priority: ident_pend first (sends 0x1B,0x2F,IDENT_BYTE, then clears pend), then key.
//  ident_req and key_valid in the same IDLE cycle: identify wins; key held (key_ready=0).
//  Timing: accept (key or ident) at cycle N -> valid=1 with first byte at N+1.
//  Output handshake: data/valid registered.
//    - data stable and valid held until ready; one byte per handshake cycle.
//    - Back-to-back bytes within a sequence: the next byte is presented on the cycle after acceptance.
//  Last byte accepted at cycle M -> IDLE at M+1 (valid=0), next accept at M+1,
//    first byte at M+2 (one bubble between sequences).
//  Unmapped key: consumed in IDLE, FSM stays IDLE, valid stays 0.
//  ready held low indefinitely: FSM stalls, no data change, key_ready=0, ident_pend still latches.
// TESTING
//  1. key 0x41 with ready=1 -> single byte 0x41, valid 1 cycle after accept, busy back to 0.
//  2. key 0x80, ready low 5 cycles then 1 -> 0x1B held stable 5 cycles, then 0x41; no extra byte.
//  3. ident_req + key_valid(0x62) same cycle -> 0x1B,0x2F,0x4B, bubble, then 0x62.
//  4. ident_req pulsed 3 times during an ESC C send -> ESC C, then exactly one ESC / K.
//  5. keys 0x90 x 300 -> no output, drop_count saturates at 0xFF; CRLF=1, key 0x0D -> 0x0D,0x0A.
//  6. reset asserted after first byte of ESC D accepted -> valid=0 immediately, no 0x44 after release.

Source files
------------

// File: rtl/vt52_key_encoder.sv
// VT52 terminal-to-host encoder: maps keyboard codes to the byte stream for the host and
// answers the host identify request (ESC Z) with ESC / <IDENT_BYTE>.
module vt52_key_encoder #(
  parameter bit          CRLF       = 1'b0,
  parameter logic [7:0]  IDENT_BYTE = 8'h4B,
  parameter int unsigned DROP_BITS  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [7:0]           key_code,
  input  logic                 key_valid,
  output logic                 key_ready,
  input  logic                 ident_req,
  output logic [7:0]           data,
  output logic                 valid,
  input  logic                 ready,
  output logic                 busy,
  output logic [DROP_BITS-1:0] drop_count
);

  localparam logic [7:0] Esc = 8'h1B;

  typedef enum logic [1:0] {StIdle, StB0, StB1, StB2} state_e;

  state_e                state_q, state_d;
  logic [7:0]            data_q, data_d;
  logic                  valid_q, valid_d;
  logic [7:0]            seq1_q, seq1_d;
  logic [7:0]            seq2_q, seq2_d;
  logic [1:0]            last_q, last_d;
  logic                  is_ident_q, is_ident_d;
  logic                  ident_pend_q, ident_pend_d;
  logic [DROP_BITS-1:0]  drop_q, drop_d;

  logic [7:0] map_b0, map_b1;
  logic [1:0] map_last;
  logic       map_drop;
  logic       seq_done;

  // Key code -> first byte, second byte and index of the last byte.
  always_comb begin
    map_b0   = key_code;
    map_b1   = 8'h0A;
    map_last = 2'd0;
    map_drop = 1'b0;
    if (!key_code[7]) begin
      if (CRLF && key_code == 8'h0D) map_last = 2'd1;
    end else begin
      map_b0   = Esc;
      map_last = 2'd1;
      case (key_code)
        8'h80:   map_b1 = 8'h41;
        8'h81:   map_b1 = 8'h42;
        8'h82:   map_b1 = 8'h43;
        8'h83:   map_b1 = 8'h44;
        8'h84:   map_b1 = 8'h50;
        8'h85:   map_b1 = 8'h51;
        8'h86:   map_b1 = 8'h52;
        default: map_drop = 1'b1;
      endcase
    end
  end

  assign key_ready  = (state_q == StIdle) & ~ident_pend_q & ~ident_req;
  assign data       = data_q;
  assign valid      = valid_q;
  assign busy       = (state_q != StIdle) | ident_pend_q;
  assign drop_count = drop_q;

  always_comb begin
    state_d      = state_q;
    data_d       = data_q;
    valid_d      = valid_q;
    seq1_d       = seq1_q;
    seq2_d       = seq2_q;
    last_d       = last_q;
    is_ident_d   = is_ident_q;
    ident_pend_d = ident_pend_q | ident_req;
    drop_d       = drop_q;
    seq_done     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (ident_pend_q || ident_req) begin
          state_d      = StB0;
          data_d       = Esc;
          seq1_d       = 8'h2F;
          seq2_d       = IDENT_BYTE;
          last_d       = 2'd2;
          is_ident_d   = 1'b1;
          valid_d      = 1'b1;
          ident_pend_d = 1'b1;
        end else if (key_valid) begin
          if (map_drop) begin
            if (drop_q != '1) drop_d = drop_q + {{(DROP_BITS-1){1'b0}}, 1'b1};
          end else begin
            state_d    = StB0;
            data_d     = map_b0;
            seq1_d     = map_b1;
            last_d     = map_last;
            is_ident_d = 1'b0;
            valid_d    = 1'b1;
          end
        end
      end
      StB0: begin
        if (ready) begin
          if (last_q == 2'd0) begin
            seq_done = 1'b1;
          end else begin
            state_d = StB1;
            data_d  = seq1_q;
          end
        end
      end
      StB1: begin
        if (ready) begin
          if (last_q == 2'd1) begin
            seq_done = 1'b1;
          end else begin
            state_d = StB2;
            data_d  = seq2_q;
          end
        end
      end
      StB2: begin
        if (ready) seq_done = 1'b1;
      end
      default: state_d = StIdle;
    endcase

    if (seq_done) begin
      state_d = StIdle;
      valid_d = 1'b0;
      data_d  = 8'h00;
      // Requests arriving during an identify send merge into the one being sent.
      if (is_ident_q) ident_pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      data_q       <= 8'h00;
      valid_q      <= 1'b0;
      seq1_q       <= 8'h00;
      seq2_q       <= 8'h00;
      last_q       <= 2'd0;
      is_ident_q   <= 1'b0;
      ident_pend_q <= 1'b0;
      drop_q       <= '0;
    end else begin
      state_q      <= state_d;
      data_q       <= data_d;
      valid_q      <= valid_d;
      seq1_q       <= seq1_d;
      seq2_q       <= seq2_d;
      last_q       <= last_d;
      is_ident_q   <= is_ident_d;
      ident_pend_q <= ident_pend_d;
      drop_q       <= drop_d;
    end
  end

endmodule
